// File: rtl/branch_seq_ctrl_if.sv
// rtl/branch_seq_ctrl_if.sv - branch request handshake between control unit and branch sequencer
//
// Purpose: bundles the branch request channel (valid/ready handshake plus payload).
// Signals:
//   br_valid  : request valid, held by the requester until br_ready is seen
//   br_ready  : sequencer can accept a request
//   br_jtrue  : 1 = jtrue, 0 = jfalse
//   br_cond   : 4-bit condition code
//   br_target : jump destination
// Modports: master = control unit (requester), slave = branch_seq_ctrl.
interface branch_seq_ctrl_if #(
   parameter int ADDR_W = 16
);
   logic              br_valid;
   logic              br_ready;
   logic              br_jtrue;
   logic [3:0]        br_cond;
   logic [ADDR_W-1:0] br_target;

   modport master (
      output br_valid, br_jtrue, br_cond, br_target,
      input  br_ready
   );

   modport slave (
      input  br_valid, br_jtrue, br_cond, br_target,
      output br_ready
   );
endinterface

// File: rtl/branch_seq_ctrl.sv
// rtl/branch_seq_ctrl.sv - conditional jump sequencer owning the flag register and the PC
//
// Purpose: accepts one jtrue/jfalse request at a time, evaluates it against the
// registered Z/C/S/O flags one cycle later, then either redirects the PC and
// flushes fetch for FLUSH_CYCLES cycles or skips the branch slot.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   alu_flags  : ALU flags, bit0=Z bit1=C bit2=S bit3=O
//   flag_we    : load alu_flags into flags_q this cycle (any state)
//   pc_adv     : fetch consumed an instruction, PC+1 while idle
//   br         : branch request channel (slave modport)
//   pc         : program counter
//   flags_q    : registered flags
//   flush      : kill in-flight fetch/decode
//   taken      : one-cycle pulse when a branch resolves taken
//   busy       : sequencer not idle
// Optional feature macro BRANCH_STATS_EN adds stat_clr, stat_taken, stat_fall.
module branch_seq_ctrl #(
   parameter int                ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int                FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        alu_flags,
   input  logic              flag_we,
   input  logic              pc_adv,
   branch_seq_ctrl_if.slave  br,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        flags_q,
   output logic              flush,
   output logic              taken,
   output logic              busy
`ifdef BRANCH_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_taken,
   output logic [15:0]       stat_fall
`endif
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EVAL     = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]        FLUSH_LD = 4'(FLUSH_CYCLES);

   state_t            state;
   logic              lat_jtrue;
   logic [3:0]        lat_cond;
   logic [ADDR_W-1:0] lat_target;
   logic [3:0]        flush_cnt;

   logic              cond_c;
   logic              cond_known;
   logic              eval_taken;

   assign br.br_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);

   // Evaluation reads flags_q as registered before this edge, so a flag_we in
   // the EVAL cycle does not affect the outcome. Unknown codes never branch.
   always_comb begin
      cond_c     = 1'b0;
      cond_known = 1'b1;
      case (lat_cond)
         4'b0100: cond_c = flags_q[2];
         4'b0101: cond_c = flags_q[0];
         4'b0110: cond_c = flags_q[1];
         4'b0111: cond_c = flags_q[0] | flags_q[2];
         4'b0000: cond_c = ~flags_q[0];
         4'b0011: cond_c = flags_q[3];
         default: cond_known = 1'b0;
      endcase
      eval_taken = cond_known & (lat_jtrue ? cond_c : ~cond_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         flags_q    <= 4'b0000;
         flush      <= 1'b0;
         taken      <= 1'b0;
         flush_cnt  <= 4'd0;
         lat_jtrue  <= 1'b0;
         lat_cond   <= 4'd0;
         lat_target <= '0;
`ifdef BRANCH_STATS_EN
         stat_taken <= 16'd0;
         stat_fall  <= 16'd0;
`endif
      end else begin
         if (flag_we)
            flags_q <= alu_flags;
         taken <= 1'b0;

         case (state)
            S_IDLE: begin
               // An accepted request holds the PC: the branch slot is skipped
               // or replaced once the outcome is known.
               if (br.br_valid) begin
                  lat_jtrue  <= br.br_jtrue;
                  lat_cond   <= br.br_cond;
                  lat_target <= br.br_target;
                  state      <= S_EVAL;
               end else if (pc_adv) begin
                  pc <= pc + PC_ONE;
               end
            end

            S_EVAL: begin
               if (eval_taken) begin
                  pc        <= lat_target;
                  taken     <= 1'b1;
                  flush     <= 1'b1;
                  flush_cnt <= FLUSH_LD;
                  state     <= S_REDIRECT;
               end else begin
                  pc    <= pc + PC_ONE;
                  state <= S_IDLE;
               end
            end

            S_REDIRECT: begin
               // flush was raised on entry, so leaving at count 1 keeps it
               // high for exactly FLUSH_CYCLES cycles.
               if (flush_cnt == 4'd1) begin
                  flush <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end

            default: begin
               flush <= 1'b0;
               state <= S_IDLE;
            end
         endcase

`ifdef BRANCH_STATS_EN
         if (stat_clr) begin
            stat_taken <= 16'd0;
            stat_fall  <= 16'd0;
         end else if (state == S_EVAL) begin
            if (eval_taken) begin
               if (stat_taken != 16'hFFFF)
                  stat_taken <= stat_taken + 16'd1;
            end else begin
               if (stat_fall != 16'hFFFF)
                  stat_fall <= stat_fall + 16'd1;
            end
         end
`endif
      end
   end

endmodule
